// File: rtl/caravel_mprj_pkg.sv
// Shared constants and types for the Caravel user-project BRAM block.
// Holds the default address windows, IO register offsets, the io_oeb reset
// value, the wait-state FSM state type and a byte-lane merge helper.
package caravel_mprj_pkg;

    localparam logic [31:0] BRAM_BASE = 32'h3800_0000;
    localparam logic [31:0] IO_BASE   = 32'h3000_0000;

    // Byte offsets of the IO registers inside the 16-byte IO window.
    localparam logic [3:0] IO_OUT_OFS    = 4'h0;
    localparam logic [3:0] IO_OUT_HI_OFS = 4'h4;
    localparam logic [3:0] IO_OEB_OFS    = 4'h8;
    localparam logic [3:0] IO_OEB_HI_OFS = 4'hC;

    localparam logic [37:0] OEB_RESET = 38'h3F_FFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StAck
    } wb_state_e;

    // Replace the bytes of old_val selected by sel with the bytes of new_val.
    function automatic logic [31:0] apply_sel(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mprj_bram.sv
// Single-port RAM, 2**AW x 32 bits, per-byte write enables, synchronous read.
// Contents are not reset.
// Ports:
//   clk_i    clock
//   en_i     access enable; read data updates only on enabled cycles
//   we_i     write enable (qualified by be_i)
//   be_i     byte enables, bit n = byte n
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  registered read data (value before any same-cycle write)
module mprj_bram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (we_i && be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/caravel_mprj_bram.sv
// Wishbone classic slave for the Caravel user area: a wait-stated program/data
// BRAM plus a small GPIO output/enable register bank.
// Ports:
//   wb_clk_i, wb_rst_i      clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i    Wishbone request and direction
//   wbs_sel_i               byte enables
//   wbs_adr_i, wbs_dat_i    byte address and write data
//   wbs_ack_o, wbs_dat_o    one-cycle ack; read data, zero when ack is low
//   io_out, io_oeb          GPIO values and active-low output enables
module caravel_mprj_bram
    import caravel_mprj_pkg::*;
#(
    parameter int unsigned DELAYS    = 10,
    parameter int unsigned BRAM_AW   = 10,
    parameter logic [31:0] BRAM_BASE = caravel_mprj_pkg::BRAM_BASE,
    parameter logic [31:0] IO_BASE   = caravel_mprj_pkg::IO_BASE
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [37:0] io_out,
    output logic [37:0] io_oeb
);

    localparam logic [7:0] DelayCnt = DELAYS[7:0];

    wb_state_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        ack_q, ack_d;
    logic        src_bram_q, src_bram_d;
    logic [31:0] dat_q, dat_d;

    logic [31:0] out_lo_q, out_lo_d;
    logic [5:0]  out_hi_q, out_hi_d;
    logic [31:0] oeb_lo_q, oeb_lo_d;
    logic [5:0]  oeb_hi_q, oeb_hi_d;

    logic        req;
    logic        bram_hit;
    logic        io_hit;
    logic [3:0]  io_ofs;
    logic [31:0] io_rdata;
    logic        io_we;
    logic        ram_en;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // Window bits above the BRAM size alias; byte-lane bits are ignored.
    logic unused_adr;
    assign unused_adr = ^{wbs_adr_i[21:BRAM_AW+2], wbs_adr_i[1:0]};

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign bram_hit = (wbs_adr_i[31:22] == BRAM_BASE[31:22]);
    assign io_hit   = (wbs_adr_i[31:4] == IO_BASE[31:4]);
    assign io_ofs   = {wbs_adr_i[3:2], 2'b00};

    // IO read mux; unmapped addresses read as zero.
    always_comb begin
        io_rdata = '0;
        if (io_hit) begin
            unique case (io_ofs)
                IO_OUT_OFS:    io_rdata = out_lo_q;
                IO_OUT_HI_OFS: io_rdata = {26'd0, out_hi_q};
                IO_OEB_OFS:    io_rdata = oeb_lo_q;
                IO_OEB_HI_OFS: io_rdata = {26'd0, oeb_hi_q};
                default:       io_rdata = '0;
            endcase
        end
    end

    // Wait-state FSM. BRAM accesses count up to DELAYS, everything else acks
    // on the first sampled edge. The ACK state forces one idle edge so a
    // request held past ack starts a fresh access.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = 1'b0;
        src_bram_d = src_bram_q;
        dat_d      = dat_q;
        io_we      = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (bram_hit) begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = StWait;
                    end else begin
                        ack_d      = 1'b1;
                        io_we      = wbs_we_i;
                        src_bram_d = 1'b0;
                        dat_d      = io_rdata;
                        state_d    = StAck;
                    end
                end
            end
            StWait: begin
                if (!req || !bram_hit) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else if (cnt_q == DelayCnt) begin
                    cnt_d      = '0;
                    ack_d      = 1'b1;
                    ram_en     = 1'b1;
                    ram_we     = wbs_we_i;
                    src_bram_d = 1'b1;
                    state_d    = StAck;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StAck: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase
    end

    // IO register next state.
    always_comb begin
        out_lo_d = out_lo_q;
        out_hi_d = out_hi_q;
        oeb_lo_d = oeb_lo_q;
        oeb_hi_d = oeb_hi_q;
        if (io_we && io_hit) begin
            unique case (io_ofs)
                IO_OUT_OFS:    out_lo_d = apply_sel(out_lo_q, wbs_dat_i, wbs_sel_i);
                IO_OUT_HI_OFS: if (wbs_sel_i[0]) out_hi_d = wbs_dat_i[5:0];
                IO_OEB_OFS:    oeb_lo_d = apply_sel(oeb_lo_q, wbs_dat_i, wbs_sel_i);
                IO_OEB_HI_OFS: if (wbs_sel_i[0]) oeb_hi_d = wbs_dat_i[5:0];
                default:       ;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            src_bram_q <= 1'b0;
            dat_q      <= '0;
            out_lo_q   <= '0;
            out_hi_q   <= '0;
            oeb_lo_q   <= OEB_RESET[31:0];
            oeb_hi_q   <= OEB_RESET[37:32];
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            src_bram_q <= src_bram_d;
            dat_q      <= dat_d;
            out_lo_q   <= out_lo_d;
            out_hi_q   <= out_hi_d;
            oeb_lo_q   <= oeb_lo_d;
            oeb_hi_q   <= oeb_hi_d;
        end
    end

    // ram_en is only raised on the ack edge, so the RAM output register holds
    // exactly the word belonging to the current ack.
    mprj_bram #(
        .AW (BRAM_AW)
    ) u_bram (
        .clk_i   (wb_clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .be_i    (wbs_sel_i),
        .addr_i  (wbs_adr_i[BRAM_AW+1:2]),
        .wdata_i (wbs_dat_i),
        .rdata_o (ram_rdata)
    );

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = ack_q ? (src_bram_q ? ram_rdata : dat_q) : 32'd0;
    assign io_out    = {out_hi_q, out_lo_q};
    assign io_oeb    = {oeb_hi_q, oeb_lo_q};

endmodule

// File: tb/tb_caravel_mprj_bram.sv
// Randomized self-checking bench for caravel_mprj_bram against a behavioural
// model of the memory map (word array for BRAM, 38-bit vectors for the GPIOs).
module tb_caravel_mprj_bram;

    localparam int unsigned Delays   = 10;
    localparam int unsigned BramAw   = 10;
    localparam logic [31:0] BramBase = 32'h3800_0000;
    localparam logic [31:0] IoBase   = 32'h3000_0000;
    localparam logic [37:0] OebAll   = 38'h3F_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc = 1'b0;
    logic        wbs_stb = 1'b0;
    logic        wbs_we = 1'b0;
    logic [3:0]  wbs_sel = 4'h0;
    logic [31:0] wbs_adr = '0;
    logic [31:0] wbs_dat_w = '0;
    logic        wbs_ack;
    logic [31:0] wbs_dat_r;
    logic [37:0] io_out_w;
    logic [37:0] io_oeb_w;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] m_mem [int];
    logic [37:0] m_out = '0;
    logic [37:0] m_oeb = OebAll;

    always #5 clk = ~clk;

    caravel_mprj_bram #(
        .DELAYS  (Delays),
        .BRAM_AW (BramAw)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_cyc_i (wbs_cyc),
        .wbs_stb_i (wbs_stb),
        .wbs_we_i  (wbs_we),
        .wbs_sel_i (wbs_sel),
        .wbs_adr_i (wbs_adr),
        .wbs_dat_i (wbs_dat_w),
        .wbs_ack_o (wbs_ack),
        .wbs_dat_o (wbs_dat_r),
        .io_out    (io_out_w),
        .io_oeb    (io_oeb_w)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bram(input logic [31:0] a);
        return a[31:22] == BramBase[31:22];
    endfunction

    function automatic bit is_io(input logic [31:0] a);
        return a[31:4] == IoBase[31:4];
    endfunction

    function automatic int exp_lat(input logic [31:0] a);
        return is_bram(a) ? int'(Delays) + 1 : 1;
    endfunction

    // Reference behaviour of one completed access.
    task automatic model_access(input logic w_en, input logic [3:0] be, input logic [31:0] addr,
                                input logic [31:0] data, output logic [31:0] exp_rd,
                                output logic known);
        int          idx;
        logic [31:0] word;
        exp_rd = '0;
        known  = 1'b1;
        if (is_bram(addr)) begin
            idx  = int'(addr[BramAw+1:2]);
            word = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
            if (w_en) begin
                for (int b = 0; b < 4; b++) if (be[b]) word[8*b +: 8] = data[8*b +: 8];
                m_mem[idx] = word;
            end else begin
                known = m_mem.exists(idx);
            end
            exp_rd = word;
        end else if (is_io(addr)) begin
            case (addr[3:2])
                2'd0: begin
                    if (w_en) for (int b = 0; b < 4; b++) if (be[b]) m_out[8*b +: 8] = data[8*b +: 8];
                    exp_rd = m_out[31:0];
                end
                2'd1: begin
                    if (w_en && be[0]) m_out[37:32] = data[5:0];
                    exp_rd = {26'd0, m_out[37:32]};
                end
                2'd2: begin
                    if (w_en) for (int b = 0; b < 4; b++) if (be[b]) m_oeb[8*b +: 8] = data[8*b +: 8];
                    exp_rd = m_oeb[31:0];
                end
                default: begin
                    if (w_en && be[0]) m_oeb[37:32] = data[5:0];
                    exp_rd = {26'd0, m_oeb[37:32]};
                end
            endcase
        end
    endtask

    // One bus access; lat is the number of edges until ack (0 on timeout).
    task automatic wb_xfer(input logic w_en, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] rd, output int lat);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = w_en;
        wbs_sel = be; wbs_adr = addr; wbs_dat_w = data;
        lat = 0;
        rd  = '0;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (wbs_ack) begin
                lat = i;
                rd  = wbs_dat_r;
                break;
            end
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        @(posedge clk); #1;
        check_eq("ack_one_cycle", {63'd0, wbs_ack}, 64'd0);
        check_eq("dat_zero_idle", {32'd0, wbs_dat_r}, 64'd0);
    endtask

    task automatic do_op(input string tag, input logic w_en, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] data,
                         output logic [31:0] rd);
        logic [31:0] exp_rd;
        logic        known;
        int          lat;
        wb_xfer(w_en, be, addr, data, rd, lat);
        model_access(w_en, be, addr, data, exp_rd, known);
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat(addr)));
        if (!w_en && known) check_eq({tag, "_rdata"}, {32'd0, rd}, {32'd0, exp_rd});
        check_eq({tag, "_io_out"}, {26'd0, io_out_w}, {26'd0, m_out});
        check_eq({tag, "_io_oeb"}, {26'd0, io_oeb_w}, {26'd0, m_oeb});
    endtask

    function automatic logic [31:0] bram_addr(input int idx);
        logic [31:0] a;
        a = BramBase | ($urandom & 32'h003F_FFFC);
        a[BramAw+1:2] = idx[BramAw-1:0];
        return a;
    endfunction

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] ua;
        logic [15:0] pat [5];
        logic [31:0] unmapped [4];
        int          n_ack;
        int          lat;
        logic        seen;

        pat      = '{16'h003E, 16'h0044, 16'h004A, 16'h0050, 16'hAB51};
        unmapped = '{32'h2000_0000, 32'h3000_0010, 32'h3840_0000, 32'h37FF_FFFC};

        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ack", {63'd0, wbs_ack}, 64'd0);
        check_eq("rst_dat", {32'd0, wbs_dat_r}, 64'd0);
        check_eq("rst_io_out", {26'd0, io_out_w}, 64'd0);
        check_eq("rst_io_oeb", {26'd0, io_oeb_w}, {26'd0, OebAll});
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed: full write / read, then byte-lane write.
        do_op("bram_wr_full", 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, rd);
        do_op("bram_rd_full", 1'b0, 4'h0, 32'h3800_0010, 32'h0, rd);
        check_eq("bram_deadbeef", {32'd0, rd}, 64'h0000_0000_DEAD_BEEF);
        do_op("bram_wr_byte", 1'b1, 4'h1, 32'h3800_0010, 32'h0000_00AB, rd);
        do_op("bram_rd_byte", 1'b0, 4'hF, 32'h3800_0010, 32'h0, rd);
        check_eq("bram_deadbeab", {32'd0, rd}, 64'h0000_0000_DEAD_BEAB);

        // Directed: GPIO patterns on io_out[31:16].
        foreach (pat[i]) begin
            do_op("io_out_wr", 1'b1, 4'hF, IoBase, {pat[i], 16'h0000}, rd);
            do_op("io_oeb_wr", 1'b1, 4'hF, IoBase + 32'h8, 32'h0, rd);
            check_eq("io_out_hi16", {48'd0, io_out_w[31:16]}, {48'd0, pat[i]});
            check_eq("io_oeb_lo32", {32'd0, io_oeb_w[31:0]}, 64'd0);
        end

        // Directed: unmapped read.
        do_op("unmapped_rd", 1'b0, 4'hF, 32'h2000_0000, 32'h0, rd);
        check_eq("unmapped_zero", {32'd0, rd}, 64'd0);

        // Give every word in the random working set a known value.
        for (int i = 0; i < 16; i++) do_op("prefill", 1'b1, 4'hF, bram_addr(i), $urandom, rd);

        for (int n = 0; n < 160; n++) begin
            case ($urandom_range(0, 5))
                0, 1: do_op("rnd_bram_wr", 1'b1, 4'($urandom), bram_addr($urandom_range(0, 15)),
                            $urandom, rd);
                2: do_op("rnd_bram_rd", 1'b0, 4'($urandom), bram_addr($urandom_range(0, 15)),
                         32'h0, rd);
                3: do_op("rnd_io_wr", 1'b1, 4'($urandom),
                         IoBase | {28'd0, 2'($urandom), 2'b00}, $urandom, rd);
                4: do_op("rnd_io_rd", 1'b0, 4'hF, IoBase | {28'd0, 2'($urandom), 2'b00}, 32'h0, rd);
                default: begin
                    ua = unmapped[$urandom_range(0, 3)];
                    do_op("rnd_unmapped", 1'($urandom), 4'hF, ua, $urandom, rd);
                end
            endcase
        end

        // Abort: write dropped after 5 cycles must not ack or commit.
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
        wbs_sel = 4'hF; wbs_adr = 32'h3800_0010; wbs_dat_w = 32'h1234_5678;
        n_ack = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (wbs_ack) n_ack++;
        end
        wbs_stb = 1'b0; wbs_cyc = 1'b0; wbs_we = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (wbs_ack) n_ack++;
        end
        check_eq("abort_no_ack", 64'(n_ack), 64'd0);
        do_op("abort_readback", 1'b0, 4'hF, 32'h3800_0010, 32'h0, rd);

        // Reset in WAIT: pending write lost, IO back to reset, counter cleared.
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
        wbs_sel = 4'hF; wbs_adr = bram_addr(5); wbs_dat_w = 32'hCAFE_F00D;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        m_out = '0;
        m_oeb = OebAll;
        check_eq("rst_wait_ack", {63'd0, wbs_ack}, 64'd0);
        check_eq("rst_wait_io_out", {26'd0, io_out_w}, {26'd0, m_out});
        check_eq("rst_wait_io_oeb", {26'd0, io_oeb_w}, {26'd0, m_oeb});
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("post_rst_read", 1'b0, 4'hF, bram_addr(5), 32'h0, rd);

        // Reset while ack is high must clear ack without a clock edge.
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
        wbs_sel = 4'hF; wbs_adr = IoBase; wbs_dat_w = 32'h5555_AAAA;
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 5; i++) begin
            @(posedge clk); #1;
            if (wbs_ack) begin
                seen = 1'b1;
                lat  = i;
                break;
            end
        end
        check_eq("async_ack_seen", {63'd0, seen}, 64'd1);
        check_eq("async_ack_lat", 64'(lat), 64'd1);
        rst = 1'b1;
        #1;
        check_eq("async_ack_clear", {63'd0, wbs_ack}, 64'd0);
        check_eq("async_dat_clear", {32'd0, wbs_dat_r}, 64'd0);
        check_eq("async_io_out", {26'd0, io_out_w}, 64'd0);
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_out = '0;
        m_oeb = OebAll;
        @(posedge clk); #1;
        do_op("final_bram_rd", 1'b0, 4'hF, 32'h3800_0010, 32'h0, rd);
        do_op("final_io_rd", 1'b0, 4'hF, IoBase + 32'h8, 32'h0, rd);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
